// File: rtl/toggle_decoder_if.sv
// Event handshake bundle between toggle_decoder (master) and its consumer (slave).
`timescale 1ns/1ps
interface toggle_decoder_if #(
    parameter int CNT_W = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic [CNT_W-1:0] pend_cnt;
    logic             overflow;
    logic [15:0]      ev_total;

    modport master (output ev_valid, pend_cnt, overflow, ev_total, input ev_ready);
    modport slave  (input ev_valid, pend_cnt, overflow, ev_total, output ev_ready);
endinterface

// File: rtl/toggle_decoder.sv
// Toggle-signalling receiver: resynchronise tog_in, turn each level change into a queued event.
// Optional glitch filter stage enabled by defining TOG_DECODE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tog_in,
    toggle_decoder_if.master  ev
);
    typedef enum logic {PRIME, RUN} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             prime_q, prime_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tog_q, tog_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            total_q, total_d;

    logic sync_out, edge_det, pop, full, accept;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign pop      = ev.ev_valid && ev.ev_ready;
    assign full     = &cnt_q;
    // A pop frees a slot in the same cycle, so an edge is only dropped when full and idle.
    assign accept   = edge_det && (pop || !full);

`ifdef TOG_DECODE_GLITCH_FILTER_EN
    logic filt_q;
    logic stable;

    always_ff @(posedge clk) begin
        if (rst) filt_q <= 1'b0;
        else     filt_q <= sync_out;
    end

    assign stable = (sync_out == filt_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRIME;
            prime_q <= '0;
            sync_q  <= '0;
            tog_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_in};
            tog_q   <= tog_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prime_d  = prime_q;
        tog_d    = sync_out;
        edge_det = 1'b0;
        case (state_q)
            PRIME: begin
                // Track the line level without edges until the sync chain holds real samples.
                prime_d = prime_q + 3'd1;
                if (prime_q == 3'(SYNC_STAGES)) state_d = RUN;
            end
            RUN: begin
`ifdef TOG_DECODE_GLITCH_FILTER_EN
                if (stable) begin
                    tog_d    = filt_q;
                    edge_det = filt_q ^ tog_q;
                end else begin
                    tog_d    = tog_q;
                end
`else
                edge_det = sync_out ^ tog_q;
`endif
            end
            default: state_d = PRIME;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        total_d = total_q;
        if (accept) total_d = total_q + 16'd1;
        if (edge_det && !pop) begin
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
        end else if (!edge_det && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign ev.ev_valid = (cnt_q != '0);
    assign ev.pend_cnt = cnt_q;
    assign ev.overflow = ovf_q;
    assign ev.ev_total = total_q;
endmodule
